// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: bundles the request, result and ALU-side signals of muldiv_seq.
//   slave  : view used by muldiv_seq (accepts requests, drives the ALU operands, returns results)
//   master : view used by the requester / ALU model (drives requests, ALU result, out_ready)
// Signals:
//   in_valid/in_ready, in_rega/in_regb/in_opcode : request handshake and operands
//   flush                                         : synchronous kill of the in-flight operation
//   alu_rega/alu_regb/alu_opcode                  : registered operands to the combinational ALU
//   alu_res/alu_divbyzero                         : ALU result and divide-by-zero flag
//   out_valid/out_ready, out_res/out_divbyzero    : result handshake and captured result
//   busy                                          : block not idle
interface muldiv_seq_if #(
  parameter int unsigned N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_rega;
  logic [N-1:0] in_regb;
  logic [4:0]   in_opcode;
  logic         flush;
  logic [N-1:0] alu_rega;
  logic [N-1:0] alu_regb;
  logic [4:0]   alu_opcode;
  logic [N-1:0] alu_res;
  logic         alu_divbyzero;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_res;
  logic         out_divbyzero;
  logic         busy;

  modport slave (
    input  in_valid, in_rega, in_regb, in_opcode, flush, alu_res, alu_divbyzero, out_ready,
    output in_ready, alu_rega, alu_regb, alu_opcode, out_valid, out_res, out_divbyzero, busy
  );

  modport master (
    output in_valid, in_rega, in_regb, in_opcode, flush, alu_res, alu_divbyzero, out_ready,
    input  in_ready, alu_rega, alu_regb, alu_opcode, out_valid, out_res, out_divbyzero, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for an external combinational multiply/divide ALU. It registers one
// request, holds the operands steady on the ALU inputs for an opcode-dependent number of settle
// cycles, captures the ALU result and presents it until the consumer takes it.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : muldiv_seq_if.slave (request, ALU and result signals)
// Parameters:
//   N       : operand/result width
//   MUL_LAT : settle cycles for MUL/MULH/MULHU/MULHSU (1..16)
//   DIV_LAT : settle cycles for DIV/DIVU/REMM/REMU (1..16)
module muldiv_seq #(
  parameter int unsigned N       = 32,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 8
) (
  input logic         clk,
  input logic         rst_n,
  muldiv_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  // Counter is loaded with LAT-1 so the capture edge lands exactly LAT edges after acceptance.
  localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 1);
  localparam logic [3:0] DivCntInit = 4'(DIV_LAT - 1);

  state_e       r_state;
  state_e       w_state_next;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_next;
  logic [3:0]   w_cnt_init;
  logic         w_accept;
  logic         w_capture;
  logic [N-1:0] r_alu_rega;
  logic [N-1:0] r_alu_regb;
  logic [4:0]   r_alu_opcode;
  logic [N-1:0] r_out_res;
  logic         r_out_divbyzero;

  // Settle time by opcode class; unknown opcodes take a single cycle.
  always_comb begin
    w_cnt_init = 4'd0;
    case (bus.in_opcode)
      5'b01001, 5'b01010, 5'b01011, 5'b01100: w_cnt_init = MulCntInit;
      5'b01101, 5'b01110, 5'b01111, 5'b10000: w_cnt_init = DivCntInit;
      default:                                w_cnt_init = 4'd0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    if (bus.flush) begin
      // Flush wins over everything, including a pending request and out_ready.
      w_state_next = StIdle;
      w_cnt_next   = 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (bus.in_valid) begin
            w_accept     = 1'b1;
            w_cnt_next   = w_cnt_init;
            w_state_next = StWait;
          end
        end
        StWait: begin
          if (r_cnt == 4'd0) begin
            w_capture    = 1'b1;
            w_state_next = StDone;
          end else begin
            w_cnt_next = r_cnt - 4'd1;
          end
        end
        StDone: begin
          if (bus.out_ready) w_state_next = StIdle;
        end
        default: begin
          w_state_next = StIdle;
          w_cnt_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Operand registers only load on acceptance, so they stay frozen through WAIT/DONE and a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_rega   <= '0;
      r_alu_regb   <= '0;
      r_alu_opcode <= 5'b00000;
    end else if (w_accept) begin
      r_alu_rega   <= bus.in_rega;
      r_alu_regb   <= bus.in_regb;
      r_alu_opcode <= bus.in_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_res       <= '0;
      r_out_divbyzero <= 1'b0;
    end else if (w_capture) begin
      r_out_res       <= bus.alu_res;
      r_out_divbyzero <= bus.alu_divbyzero;
    end
  end

  // Status outputs decode the state register only, so reset clears them without a clock edge
  // and in_ready has no path from out_ready.
  assign bus.in_ready      = (r_state == StIdle);
  assign bus.out_valid     = (r_state == StDone);
  assign bus.busy          = (r_state != StIdle);
  assign bus.alu_rega      = r_alu_rega;
  assign bus.alu_regb      = r_alu_regb;
  assign bus.alu_opcode    = r_alu_opcode;
  assign bus.out_res       = r_out_res;
  assign bus.out_divbyzero = r_out_divbyzero;

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter N, default 32: operand and result width.
REQ-002 Parameter MUL_LAT, default 2: settle cycles for MUL/MULH/MULHU/MULHSU; legal range 1..16.
REQ-003 Parameter DIV_LAT, default 8: settle cycles for DIV/DIVU/REMM/REMU; legal range 1..16.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 in_rega / in_regb  in  N each  source operands.
REQ-009 in_opcode  in  5  ALU opcode: MUL=01001, MULH=01010, MULHU=01011, MULHSU=01100, DIV=01101, DIVU=01110, REMM=01111, REMU=10000.
REQ-010 flush  in  1  synchronous kill of the in-flight operation.
REQ-011 alu_rega / alu_regb  out  N each  registered operands driven to the combinational mul/div ALU.
REQ-012 alu_opcode  out  5  registered opcode driven to the ALU.
REQ-013 alu_res  in  N  ALU result.
REQ-014 alu_divbyzero  in  1  ALU divide-by-zero flag.
REQ-015 out_valid  out  1  result available.
REQ-016 out_ready  in  1  consumer accepts result.
REQ-017 out_res  out  N  captured result.
REQ-018 out_divbyzero  out  1  captured divide-by-zero flag.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 FSM states: IDLE, WAIT, DONE; in_ready SHALL be 1 only in IDLE, with no combinational path from out_ready.
REQ-021 Acceptance: in_valid & in_ready & ~flush at an edge latches in_rega, in_regb and in_opcode into the alu_* registers, loads a 4-bit counter with LAT-1, and enters WAIT.
REQ-022 LAT SHALL be MUL_LAT for opcodes 01001..01100, DIV_LAT for 01101..10000, and 1 for any other opcode.
REQ-023 WAIT: the counter decrements by 1 each edge; at the edge where it reads 0, alu_res and alu_divbyzero are captured into out_res and out_divbyzero, and the FSM enters DONE.
REQ-024 Latency: out_valid SHALL rise exactly LAT edges after the acceptance edge.
REQ-025 The alu_* registers SHALL hold constant from the acceptance edge through the whole of WAIT and DONE.
REQ-026 DONE: out_valid=1; out_res and out_divbyzero hold stable until out_ready=1, which returns the FSM to IDLE at that edge.
REQ-027 The block SHALL accept no request in WAIT or DONE; peak throughput is one operation per LAT+2 cycles.
REQ-028 flush has the highest priority: at the edge it is sampled, the FSM goes to IDLE, out_valid goes to 0, the counter clears, and the alu_* registers keep their values.
REQ-029 flush and in_valid in the same cycle: the request is not accepted.
REQ-030 flush in DONE discards the result; out_ready is ignored at that edge.
REQ-031 The block performs no arithmetic; results and the flag come solely from alu_res and alu_divbyzero.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force: state=IDLE, counter=0, alu_rega=alu_regb=0, alu_opcode=00000, out_res=0, out_divbyzero=0, out_valid=0, busy=0, in_ready=1.
REQ-033 Reset asserted mid-WAIT or mid-DONE SHALL abandon the operation; no out_valid pulse appears after release.
REQ-034 After rst_n deasserts, the first edge may accept a request.

Verification
REQ-035 MUL, rega=7, regb=0xFFFFFFFD, MUL_LAT=2 -> in_ready=0 at the next edge, out_valid rises 2 edges after acceptance, out_res=0xFFFFFFEB, out_divbyzero=0.
REQ-036 DIVU, rega=100, regb=0, DIV_LAT=8 -> out_valid 8 edges after acceptance, out_res=0xFFFFFFFF, out_divbyzero=1.
REQ-037 REMM, rega=0xFFFFFFF9, regb=2, out_ready held low 5 cycles -> out_res=0xFFFFFFFF stable, in_ready=0 throughout; out_ready=1 -> IDLE and in_ready=1 next cycle.
REQ-038 DIV issued, flush at the 3rd WAIT cycle -> busy=0 next cycle and out_valid never rises; next MULHU 0xFFFFFFFF*0xFFFFFFFF -> out_res=0xFFFFFFFE.
REQ-039 rst_n pulsed low while in DONE -> out_valid=0, in_ready=1 immediately, without waiting for a clock edge.
REQ-040 Illegal opcode 00011, rega=5, regb=6 -> out_valid 1 edge after acceptance, out_res=0, out_divbyzero=0.
